// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, width helper and constants for the multi-port register file
package regfile_pkg;

    localparam int DEF_W     = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_NR    = 2;
    localparam int DEF_NW    = 1;

    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    localparam int DEF_AW = addr_w(DEF_DEPTH);

    typedef logic [DEF_AW-1:0]       addr_t;
    typedef logic [DEF_W-1:0]        data_t;
    typedef logic [DEF_NR-1:0]       rd_vec_t;
    typedef logic [DEF_NW-1:0]       wr_vec_t;

    localparam addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits with set-over-clear priority and registered popcount
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DEPTH-1:0] set,
    input  logic [DEPTH-1:0] clr,
    output logic [DEPTH-1:0] busy,
    output logic [AW:0]      busy_cnt
);

    logic [DEPTH-1:0] busy_next;
    logic [AW:0]      cnt_next;

    // A new issue beats a completing write: the register has a fresh producer.
    always_comb begin
        busy_next = (busy & ~clr) | set;
        cnt_next  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_next = cnt_next + (AW+1)'(busy_next[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with hardwired x0, write bypass and busy scoreboard
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int W       = 32,
    parameter int DEPTH   = 32,
    parameter int NR      = 2,
    parameter int NW      = 1,
    parameter int ZERO_X0 = 1,
    parameter int BYPASS  = 1,
    parameter int AW      = addr_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NW-1:0]    wr_en_i,
    input  logic [NW*AW-1:0] wr_addr_i,
    input  logic [NW*W-1:0]  wr_data_i,
    input  logic [NR*AW-1:0] rs_addr_i,
    output logic [NR*W-1:0]  rs_data_o,
    output logic [NR-1:0]    rs_busy_o,
    input  logic             issue_en_i,
    input  logic [AW-1:0]    issue_addr_i,
    output logic [AW:0]      busy_cnt_o
);

    logic [W-1:0]     regs [DEPTH];
    logic [NW-1:0]    live;
    logic [DEPTH-1:0] set;
    logic [DEPTH-1:0] clr;
    logic [DEPTH-1:0] busy;
    logic [AW-1:0]    ra;
    logic [W-1:0]     rd;
    logic             rb;

    always_comb begin
        live = '0;
        clr  = '0;
        set  = '0;
        for (int p = 0; p < NW; p++) begin
            live[p] = wr_en_i[p] &&
                      !((ZERO_X0 != 0) && (wr_addr_i[p*AW +: AW] == AW'(ZERO_ADDR)));
            if (live[p]) begin
                clr[wr_addr_i[p*AW +: AW]] = 1'b1;
            end
        end
        if (issue_en_i && !((ZERO_X0 != 0) && (issue_addr_i == AW'(ZERO_ADDR)))) begin
            set[issue_addr_i] = 1'b1;
        end
    end

    // Ports applied in ascending order so the highest index wins a shared address.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NW; p++) begin
                if (live[p]) begin
                    regs[wr_addr_i[p*AW +: AW]] <= wr_data_i[p*W +: W];
                end
            end
        end
    end

    // Forwarding is suppressed while in reset so reads show the cleared state.
    always_comb begin
        rs_data_o = '0;
        rs_busy_o = '0;
        ra        = '0;
        rd        = '0;
        rb        = 1'b0;
        for (int r = 0; r < NR; r++) begin
            ra = rs_addr_i[r*AW +: AW];
            rd = regs[ra];
            if ((BYPASS != 0) && rst_i) begin
                for (int p = 0; p < NW; p++) begin
                    if (live[p] && (wr_addr_i[p*AW +: AW] == ra)) begin
                        rd = wr_data_i[p*W +: W];
                    end
                end
            end
            if ((ZERO_X0 != 0) && (ra == AW'(ZERO_ADDR))) begin
                rd = '0;
            end
            rb = busy[ra];
            if ((BYPASS != 0) && clr[ra] && !set[ra]) begin
                rb = 1'b0;
            end
            rs_data_o[r*W +: W] = rd;
            rs_busy_o[r]        = rb;
        end
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_scoreboard (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .set      (set),
        .clr      (clr),
        .busy     (busy),
        .busy_cnt (busy_cnt_o)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized and directed checks of regfile_mp against a behavioural model
module tb_regfile_mp;

    localparam int W = 32, DEPTH = 32, NR = 2, NW = 2, AW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [NW-1:0]   wen;
    logic [NW*AW-1:0] waddr;
    logic [NW*W-1:0] wdata;
    logic [NR*AW-1:0] raddr;
    logic [NR*W-1:0] rdata_b, rdata_n;
    logic [NR-1:0]   rbusy_b, rbusy_n;
    logic            ien;
    logic [AW-1:0]   iaddr;
    logic [AW:0]     cnt_b, cnt_n;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] mem [DEPTH];
    bit           bsy [DEPTH];

    always #5 clk = ~clk;

    regfile_mp #(.W(W), .DEPTH(DEPTH), .NR(NR), .NW(NW), .ZERO_X0(1), .BYPASS(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wen), .wr_addr_i(waddr), .wr_data_i(wdata),
        .rs_addr_i(raddr), .rs_data_o(rdata_b), .rs_busy_o(rbusy_b),
        .issue_en_i(ien), .issue_addr_i(iaddr), .busy_cnt_o(cnt_b));

    regfile_mp #(.W(W), .DEPTH(DEPTH), .NR(NR), .NW(NW), .ZERO_X0(1), .BYPASS(0)) dut_n (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wen), .wr_addr_i(waddr), .wr_data_i(wdata),
        .rs_addr_i(raddr), .rs_data_o(rdata_n), .rs_busy_o(rbusy_n),
        .issue_en_i(ien), .issue_addr_i(iaddr), .busy_cnt_o(cnt_n));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit wr_hits(input logic [AW-1:0] a);
        for (int p = 0; p < NW; p++)
            if (wen[p] && waddr[p*AW +: AW] == a && a != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] m_read(input logic [AW-1:0] a, input bit byp);
        logic [W-1:0] v;
        if (a == 0 || !rst) return '0;
        v = mem[a];
        if (byp)
            for (int p = 0; p < NW; p++)
                if (wen[p] && waddr[p*AW +: AW] == a) v = wdata[p*W +: W];
        return v;
    endfunction

    function automatic bit m_busy(input logic [AW-1:0] a, input bit byp);
        if (byp && wr_hits(a) && !(ien && iaddr == a && a != 0)) return 1'b0;
        return bsy[a];
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(bsy[i]);
        return c;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            bsy[i] = 1'b0;
        end
    endtask

    task automatic m_update();
        for (int p = 0; p < NW; p++)
            if (wen[p] && waddr[p*AW +: AW] != 0) begin
                mem[waddr[p*AW +: AW]] = wdata[p*W +: W];
                bsy[waddr[p*AW +: AW]] = 1'b0;
            end
        if (ien && iaddr != 0) bsy[iaddr] = 1'b1;
    endtask

    task automatic check_all();
        for (int r = 0; r < NR; r++) begin
            check("rd_byp",  rdata_b[r*W +: W], m_read(raddr[r*AW +: AW], 1'b1));
            check("rd_nbyp", rdata_n[r*W +: W], m_read(raddr[r*AW +: AW], 1'b0));
            check("bsy_byp",  rbusy_b[r], m_busy(raddr[r*AW +: AW], 1'b1));
            check("bsy_nbyp", rbusy_n[r], m_busy(raddr[r*AW +: AW], 1'b0));
        end
        check("cnt_byp",  cnt_b, m_count());
        check("cnt_nbyp", cnt_n, m_count());
    endtask

    task automatic idle();
        wen = '0; waddr = '0; wdata = '0; raddr = '0; ien = 1'b0; iaddr = '0;
    endtask

    // Inputs already driven just after a negedge; check, clock, update model.
    task automatic cycle();
        #1 check_all();
        @(posedge clk);
        if (rst) m_update();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        idle();
        m_clear();
        @(negedge clk);
        #1 check_all();
        @(negedge clk);
        rst = 1'b1;

        wen = 2'b01; waddr[4:0] = 5'd5; wdata[31:0] = 32'hDEADBEEF;
        cycle();
        idle(); raddr[4:0] = 5'd5;
        #1 check("x5_read", rdata_b[31:0], 32'hDEADBEEF);
        cycle();
        wen = 2'b01; waddr[4:0] = 5'd0; wdata[31:0] = 32'h1234;
        cycle();
        idle();
        #1 check("x0_read", rdata_b[31:0], 32'h0);
        cycle();

        wen = 2'b01; waddr[4:0] = 5'd7; wdata[31:0] = 32'hA5A5A5A5; raddr[9:5] = 5'd7;
        #1 check("byp_x7", rdata_b[63:32], 32'hA5A5A5A5);
        check("nbyp_x7", rdata_n[63:32], 32'h0);
        cycle();

        idle(); wen = 2'b11; waddr = {5'd3, 5'd3}; wdata = {32'h22, 32'h11};
        cycle();
        idle(); raddr[4:0] = 5'd3;
        #1 check("conflict_x3", rdata_b[31:0], 32'h22);
        cycle();

        idle(); ien = 1'b1; iaddr = 5'd9;
        cycle();
        idle(); raddr[4:0] = 5'd9;
        #1 check("x9_busy", rbusy_b[0], 1'b1);
        check("x9_cnt1", cnt_b, 6'd1);
        wen = 2'b01; waddr[4:0] = 5'd9; wdata[31:0] = 32'h99;
        cycle();
        idle(); raddr[4:0] = 5'd9;
        #1 check("x9_clear", rbusy_b[0], 1'b0);
        check("x9_cnt0", cnt_b, 6'd0);
        ien = 1'b1; iaddr = 5'd9; wen = 2'b01; waddr[4:0] = 5'd9; wdata[31:0] = 32'h98;
        cycle();
        idle(); raddr[4:0] = 5'd9;
        #1 check("x9_reissue", rbusy_b[0], 1'b1);
        cycle();

        for (int a = 1; a < DEPTH; a++) begin
            idle(); ien = 1'b1; iaddr = AW'(a);
            cycle();
        end
        idle();
        #1 check("fill_cnt", cnt_b, 6'd31);
        ien = 1'b1; iaddr = 5'd0;
        cycle();
        idle();
        #1 check("fill_x0", cnt_b, 6'd31);

        wen = 2'b01; waddr[4:0] = 5'd12; wdata[31:0] = 32'hCAFE; raddr = {5'd3, 5'd5};
        ien = 1'b1; iaddr = 5'd14;
        #2 rst = 1'b0;
        m_clear();
        #1 check("rst_rd0", rdata_b[31:0], 32'h0);
        check("rst_rd1", rdata_b[63:32], 32'h0);
        check("rst_busy", {30'b0, rbusy_b}, 32'h0);
        check("rst_cnt", cnt_b, 6'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(); raddr[4:0] = 5'd12;
        #1 check("rst_nowrite", rdata_b[31:0], 32'h0);
        cycle();

        for (int i = 0; i < 600; i++) begin
            wen = NW'($urandom);
            for (int p = 0; p < NW; p++) begin
                waddr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
                wdata[p*W +: W]   = $urandom;
            end
            for (int r = 0; r < NR; r++)
                raddr[r*AW +: AW] = ($urandom_range(0, 2) == 0) ? waddr[($urandom_range(0, NW-1))*AW +: AW] : AW'($urandom);
            ien   = ($urandom_range(0, 2) != 0);
            iaddr = ($urandom_range(0, 3) == 0) ? waddr[AW-1:0] : AW'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #3 rst = 1'b0;
                m_clear();
                #1 check_all();
                @(negedge clk);
                rst = 1'b1;
            end else begin
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
